// File: rtl/cam_array_if.sv
// Bundle of write/invalidate, search and result signals for cam_array.
// Latency: none (wires only); result timing is set by cam_array.
// Backpressure: none; every write and search is accepted the cycle it is presented.
//
// master : drives write/invalidate/search requests, receives registered results
// slave  : the CAM itself
// search_mask_i exists only when CAM_MASK_EN is defined.
interface cam_array_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              write_enable_i;
    logic              invalidate_i;
    logic [IDX_W-1:0]  write_addr_i;
    logic [WIDTH-1:0]  write_data_i;
    logic              search_enable_i;
    logic [WIDTH-1:0]  search_i;
`ifdef CAM_MASK_EN
    logic [WIDTH-1:0]  search_mask_i;
`endif
    logic              match_valid_o;
    logic [DEPTH-1:0]  match_vec_o;
    logic              hit_o;
    logic [IDX_W-1:0]  hit_index_o;
    logic              multi_hit_o;
    logic [IDX_W:0]    count_o;

    modport master (
`ifdef CAM_MASK_EN
        output search_mask_i,
`endif
        output write_enable_i, invalidate_i, write_addr_i, write_data_i,
        output search_enable_i, search_i,
        input  match_valid_o, match_vec_o, hit_o, hit_index_o, multi_hit_o, count_o
    );

    modport slave (
`ifdef CAM_MASK_EN
        input  search_mask_i,
`endif
        input  write_enable_i, invalidate_i, write_addr_i, write_data_i,
        input  search_enable_i, search_i,
        output match_valid_o, match_vec_o, hit_o, hit_index_o, multi_hit_o, count_o
    );
endinterface

// File: rtl/cam_array.sv
// DEPTH x WIDTH content-addressable memory with valid bits, lowest-index priority encode and occupancy count.
// Latency: search results registered 1 cycle after search_enable_i; write/invalidate visible to the next search.
// Backpressure: none; one write-or-invalidate and one search accepted every cycle.
//
// Ports: clk, reset (synchronous, active-high) plus cam_array_if.slave bus carrying
//   write_enable_i/invalidate_i/write_addr_i/write_data_i (entry update),
//   search_enable_i/search_i[/search_mask_i] (lookup) and
//   match_valid_o/match_vec_o/hit_o/hit_index_o/multi_hit_o/count_o (results, occupancy).
// Optional feature: define CAM_MASK_EN to add search_mask_i (1 = compare bit, 0 = don't care).
module cam_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    cam_array_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);

    // Storage
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [IDX_W:0]   count_q;

    // Registered search results
    logic             match_valid_q;
    logic [DEPTH-1:0] match_vec_q;
    logic             hit_q;
    logic [IDX_W-1:0] hit_index_q;
    logic             multi_hit_q;

    // Combinational compare against the current (pre-update) contents, which
    // gives read-before-write for a search launched alongside a write/invalidate.
    logic [WIDTH-1:0] cmp_mask;
    logic [DEPTH-1:0] match_now;
    logic [IDX_W-1:0] first_idx;
    logic             multi_now;

`ifdef CAM_MASK_EN
    assign cmp_mask = bus.search_mask_i;
`else
    assign cmp_mask = {WIDTH{1'b1}};
`endif

    always_comb begin
        match_now = '0;
        for (int e = 0; e < DEPTH; e++) begin
            match_now[e] = valid_q[e] && (((data_q[e] ^ bus.search_i) & cmp_mask) == '0);
        end
    end

    // Scan from the top down so the lowest matching index is the last assignment.
    always_comb begin
        first_idx = '0;
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (match_now[e]) begin
                first_idx = IDX_W'(e);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_now = |(match_now & (match_now - DEPTH'(1)));

    // Occupancy only moves when the valid bit actually flips; write beats invalidate.
    logic cnt_inc;
    logic cnt_dec;
    assign cnt_inc = bus.write_enable_i && !valid_q[bus.write_addr_i];
    assign cnt_dec = !bus.write_enable_i && bus.invalidate_i && valid_q[bus.write_addr_i];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                data_q[e] <= '0;
            end
            valid_q       <= '0;
            count_q       <= '0;
            match_valid_q <= 1'b0;
            match_vec_q   <= '0;
            hit_q         <= 1'b0;
            hit_index_q   <= '0;
            multi_hit_q   <= 1'b0;
        end else begin
            if (bus.write_enable_i) begin
                data_q[bus.write_addr_i]  <= bus.write_data_i;
                valid_q[bus.write_addr_i] <= 1'b1;
            end else if (bus.invalidate_i) begin
                valid_q[bus.write_addr_i] <= 1'b0;
            end

            if (cnt_inc) begin
                count_q <= count_q + 1'b1;
            end else if (cnt_dec) begin
                count_q <= count_q - 1'b1;
            end

            // Result registers hold their last value between searches.
            match_valid_q <= bus.search_enable_i;
            if (bus.search_enable_i) begin
                match_vec_q <= match_now;
                hit_q       <= |match_now;
                hit_index_q <= first_idx;
                multi_hit_q <= multi_now;
            end
        end
    end

    assign bus.match_valid_o = match_valid_q;
    assign bus.match_vec_o   = match_vec_q;
    assign bus.hit_o         = hit_q;
    assign bus.hit_index_o   = hit_index_q;
    assign bus.multi_hit_o   = multi_hit_q;
    assign bus.count_o       = count_q;

endmodule

// File: tb/tb_cam_array.sv
module tb_cam_array;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int IDX_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cam_array_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    cam_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain arrays of words and valid flags.
    logic [WIDTH-1:0] m_data  [DEPTH];
    bit               m_valid [DEPTH];
    logic             e_mv;
    logic [DEPTH-1:0] e_vec;
    logic             e_hit;
    logic [IDX_W-1:0] e_idx;
    logic             e_multi;

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one cycle of inputs, let the edge happen, then advance the model.
    task automatic step(input logic we, input logic inv, input logic [IDX_W-1:0] addr,
                        input logic [WIDTH-1:0] wd, input logic se, input logic [WIDTH-1:0] key,
                        input logic [WIDTH-1:0] mask, input logic rst);
        logic [WIDTH-1:0] mask_eff;
        reset               = rst;
        bus.write_enable_i  = we;
        bus.invalidate_i    = inv;
        bus.write_addr_i    = addr;
        bus.write_data_i    = wd;
        bus.search_enable_i = se;
        bus.search_i        = key;
`ifdef CAM_MASK_EN
        bus.search_mask_i   = mask;
        mask_eff            = mask;
`else
        mask_eff            = {WIDTH{1'b1}};
`endif
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_data[i]  = '0;
                m_valid[i] = 1'b0;
            end
            e_mv = 0; e_vec = '0; e_hit = 0; e_idx = '0; e_multi = 0;
        end else begin
            if (se) begin
                e_mv  = 1'b1;
                e_vec = '0;
                for (int i = 0; i < DEPTH; i++)
                    if (m_valid[i] && ((m_data[i] & mask_eff) == (key & mask_eff))) e_vec[i] = 1'b1;
                e_hit = (e_vec != '0);
                e_idx = '0;
                for (int i = 0; i < DEPTH; i++)
                    if (e_vec[i]) begin
                        e_idx = IDX_W'(i);
                        break;
                    end
                e_multi = ($countones(e_vec) > 1);
            end else begin
                e_mv = 1'b0;
            end
            if (we) begin
                m_data[addr]  = wd;
                m_valid[addr] = 1'b1;
            end else if (inv) begin
                m_valid[addr] = 1'b0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".match_valid"}, 32'(bus.match_valid_o), 32'(e_mv));
        check({tag, ".match_vec"},   32'(bus.match_vec_o),   32'(e_vec));
        check({tag, ".hit"},         32'(bus.hit_o),         32'(e_hit));
        check({tag, ".hit_index"},   32'(bus.hit_index_o),   32'(e_idx));
        check({tag, ".multi_hit"},   32'(bus.multi_hit_o),   32'(e_multi));
        check({tag, ".count"},       32'(bus.count_o),       32'(model_count()));
    endtask

    task automatic check_const(input string tag, input logic mv, input logic [DEPTH-1:0] vec,
                               input logic hit, input logic [IDX_W-1:0] idx, input logic multi, input int cnt);
        check({tag, ".match_valid"}, 32'(bus.match_valid_o), 32'(mv));
        check({tag, ".match_vec"},   32'(bus.match_vec_o),   32'(vec));
        check({tag, ".hit"},         32'(bus.hit_o),         32'(hit));
        check({tag, ".hit_index"},   32'(bus.hit_index_o),   32'(idx));
        check({tag, ".multi_hit"},   32'(bus.multi_hit_o),   32'(multi));
        check({tag, ".count"},       32'(bus.count_o),       32'(cnt));
    endtask

    typedef struct {
        logic             we;
        logic             inv;
        logic [IDX_W-1:0] addr;
        logic [WIDTH-1:0] wd;
        logic             se;
        logic [WIDTH-1:0] key;
        logic             mv;
        logic [DEPTH-1:0] vec;
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic             multi;
        int               cnt;
    } vec_t;

    function automatic vec_t mk(logic we, logic inv, logic [IDX_W-1:0] addr, logic [WIDTH-1:0] wd,
                                logic se, logic [WIDTH-1:0] key, logic mv, logic [DEPTH-1:0] vec,
                                logic hit, logic [IDX_W-1:0] idx, logic multi, int cnt);
        vec_t v;
        v.we = we; v.inv = inv; v.addr = addr; v.wd = wd; v.se = se; v.key = key;
        v.mv = mv; v.vec = vec; v.hit = hit; v.idx = idx; v.multi = multi; v.cnt = cnt;
        return v;
    endfunction

    localparam logic [WIDTH-1:0] ALL1 = {WIDTH{1'b1}};

    initial begin
        vec_t tbl [13];
        //            we inv addr wd     se key    mv vec        hit idx multi cnt
        tbl[0]  = mk(0, 0, 0, 8'h00, 1, 8'h00, 1, 16'h0000, 0, 0, 0, 0); // zeroed invalid entries miss
        tbl[1]  = mk(1, 0, 3, 8'hA5, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 1);
        tbl[2]  = mk(1, 0, 9, 8'hA5, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 2);
        tbl[3]  = mk(0, 0, 0, 8'h00, 1, 8'hA5, 1, 16'h0208, 1, 3, 1, 2);
        tbl[4]  = mk(1, 0, 5, 8'h3C, 1, 8'h3C, 1, 16'h0000, 0, 0, 0, 3); // read-before-write
        tbl[5]  = mk(0, 0, 0, 8'h00, 1, 8'h3C, 1, 16'h0020, 1, 5, 0, 3);
        tbl[6]  = mk(0, 1, 3, 8'h00, 0, 8'h00, 0, 16'h0020, 1, 5, 0, 2); // results hold
        tbl[7]  = mk(0, 0, 0, 8'h00, 1, 8'hA5, 1, 16'h0200, 1, 9, 0, 2);
        tbl[8]  = mk(0, 1, 3, 8'h00, 0, 8'h00, 0, 16'h0200, 1, 9, 0, 2); // invalidate invalid entry
        tbl[9]  = mk(1, 1, 9, 8'hA5, 0, 8'h00, 0, 16'h0200, 1, 9, 0, 2); // write wins
        tbl[10] = mk(0, 0, 0, 8'h00, 1, 8'hA5, 1, 16'h0200, 1, 9, 0, 2);
        tbl[11] = mk(0, 1, 9, 8'h00, 1, 8'hA5, 1, 16'h0200, 1, 9, 0, 1); // invalidate unseen by same search
        tbl[12] = mk(0, 0, 0, 8'h00, 1, 8'hA5, 1, 16'h0000, 0, 0, 0, 1);

        step(0, 0, 0, 0, 0, 0, ALL1, 1);
        step(0, 0, 0, 0, 0, 0, ALL1, 1);
        check_const("reset", 0, '0, 0, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].we, tbl[i].inv, tbl[i].addr, tbl[i].wd, tbl[i].se, tbl[i].key, ALL1, 0);
            check_const($sformatf("tbl%0d", i), tbl[i].mv, tbl[i].vec, tbl[i].hit,
                        tbl[i].idx, tbl[i].multi, tbl[i].cnt);
        end

        // Fill every entry; entry 5 is already valid so it does not bump the count.
        for (int e = 0; e < DEPTH; e++) begin
            step(1, 0, IDX_W'(e), 8'h10 + 8'(e), 0, 0, ALL1, 0);
            check($sformatf("fill%0d.count", e), 32'(bus.count_o), (e < 5) ? 32'(e + 2) : 32'(e + 1));
        end
        step(1, 0, 0, 8'h77, 0, 0, ALL1, 0);
        check("rewrite0.count", 32'(bus.count_o), 32'd16);
        step(0, 0, 0, 0, 1, 8'h77, ALL1, 0);
        check_const("full_search", 1, 16'h0001, 1, 0, 0, 16);
        step(0, 0, 0, 0, 1, 8'h1F, ALL1, 0);
        check_const("full_search_top", 1, 16'h8000, 1, 15, 0, 16);

        // Reset with a write and a search presented: both discarded.
        step(1, 0, 4, 8'h77, 1, 8'h77, ALL1, 1);
        check_const("mid_reset", 0, '0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 8'h77, ALL1, 0);
        check_const("post_reset_search", 1, '0, 0, 0, 0, 0);

`ifdef CAM_MASK_EN
        step(1, 0, 2, 8'hF0, 0, 0, ALL1, 0);
        step(0, 0, 0, 0, 1, 8'hFF, 8'hF0, 0);
        check_const("mask_f0", 1, 16'h0004, 1, 2, 0, 1);
        step(0, 0, 0, 0, 1, 8'hFF, 8'hFF, 0);
        check_const("mask_ff", 1, 16'h0000, 0, 0, 0, 1);
        step(1, 0, 7, 8'h01, 0, 0, ALL1, 0);
        step(0, 0, 0, 0, 1, 8'h5A, 8'h00, 0);
        check_const("mask_zero", 1, 16'h0084, 1, 2, 1, 2);
`endif

        // Randomised traffic against the model; small data space keeps hits frequent.
        for (int n = 0; n < 600; n++) begin
            logic r_we, r_inv, r_se, r_rst;
            logic [IDX_W-1:0] r_addr;
            logic [WIDTH-1:0] r_wd, r_key, r_mask;
            r_we   = ($urandom_range(0, 2) == 0);
            r_inv  = ($urandom_range(0, 3) == 0);
            r_se   = ($urandom_range(0, 1) == 0);
            r_rst  = ($urandom_range(0, 79) == 0);
            r_addr = IDX_W'($urandom_range(0, DEPTH - 1));
            r_wd   = WIDTH'($urandom_range(0, 3));
            r_key  = WIDTH'($urandom_range(0, 3));
            r_mask = ($urandom_range(0, 1) == 0) ? ALL1 : WIDTH'($urandom);
            step(r_we, r_inv, r_addr, r_wd, r_se, r_key, r_mask, r_rst);
            check_model($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
